// File: rtl/add2_acc.sv
// rtl/add2_acc.sv - frame accumulator for 3-bit adder results with held output handshake
module add2_acc #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4,
  localparam int CW = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic             c1,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic [ACC_W:0]   smp_ext;
  logic [ACC_W:0]   sum_ext;
  logic             accept;
  logic             close;
  logic [ACC_W-1:0] acc_upd;
  logic [CW-1:0]    cnt_upd;
  logic             ovf_upd;

  // Ready/valid come straight from the registered state so neither depends on the far side.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // Post-accept accumulator values and the frame-close decision for this edge.
  always_comb begin
    smp_ext = {{(ACC_W - 2){1'b0}}, c1, s1, s0};
    sum_ext = {1'b0, acc} + smp_ext;
    accept  = in_valid && (state == ACCUM);
    acc_upd = accept ? sum_ext[ACC_W-1:0] : acc;
    cnt_upd = accept ? cnt + CW'(1) : cnt;
    ovf_upd = ovf | (accept & sum_ext[ACC_W]);
    close   = (state == ACCUM) &&
              ((accept && (cnt == CW'(COUNT - 1))) ||
               (flush && ((cnt != '0) || accept)));
  end

  // Two-state frame machine: accumulate until the frame closes, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            out_sum   <= acc_upd;
            out_count <= cnt_upd;
            out_ovf   <= ovf_upd;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= HOLD;
          end else begin
            acc <= acc_upd;
            cnt <= cnt_upd;
            ovf <= ovf_upd;
          end
        end
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_add2_acc.sv
// tb/tb_add2_acc.sv - self-checking bench for add2_acc across three parameter sets
module tb_add2_acc;

  localparam int NI = 3;
  localparam int WV [NI] = '{8, 4, 8};
  localparam int CV [NI] = '{4, 4, 16};

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [NI];
  logic       fl   [NI];
  logic       ordy [NI];
  logic [2:0] smp  [NI];

  logic       ir   [NI];
  logic       ov   [NI];
  logic       oovf [NI];
  logic [7:0] osum [NI];
  logic [4:0] ocnt [NI];

  logic [7:0] osum_a, osum_c;
  logic [3:0] osum_b;
  logic [2:0] ocnt_a, ocnt_b;
  logic [4:0] ocnt_c;

  int passed = 0;
  int total  = 0;

  // reference model state: frame collected so far and the result word expected on the outputs
  bit held [NI];
  int q_sum [NI];
  int q_n   [NI];
  int e_sum [NI];
  int e_cnt [NI];
  int e_ovf [NI];

  always #5 clk = ~clk;

  add2_acc #(.ACC_W(8), .COUNT(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .s0(smp[0][0]), .s1(smp[0][1]), .c1(smp[0][2]), .flush(fl[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(osum_a),
    .out_count(ocnt_a), .out_ovf(oovf[0]));

  add2_acc #(.ACC_W(4), .COUNT(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .s0(smp[1][0]), .s1(smp[1][1]), .c1(smp[1][2]), .flush(fl[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(osum_b),
    .out_count(ocnt_b), .out_ovf(oovf[1]));

  add2_acc #(.ACC_W(8), .COUNT(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .s0(smp[2][0]), .s1(smp[2][1]), .c1(smp[2][2]), .flush(fl[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(osum_c),
    .out_count(ocnt_c), .out_ovf(oovf[2]));

  assign osum[0] = osum_a;
  assign osum[1] = {4'b0, osum_b};
  assign osum[2] = osum_c;
  assign ocnt[0] = {2'b0, ocnt_a};
  assign ocnt[1] = {2'b0, ocnt_b};
  assign ocnt[2] = ocnt_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  // one clock edge: advance the frame model with the inputs seen at the edge, then compare
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        held[i] = 1'b0; q_sum[i] = 0; q_n[i] = 0;
        e_sum[i] = 0; e_cnt[i] = 0; e_ovf[i] = 0;
      end else if (!held[i]) begin
        if (iv[i]) begin
          q_sum[i] += int'(smp[i]);
          q_n[i]++;
        end
        if ((iv[i] && q_n[i] == CV[i]) || (fl[i] && q_n[i] > 0)) begin
          e_sum[i] = q_sum[i] % (1 << WV[i]);
          e_cnt[i] = q_n[i];
          e_ovf[i] = (q_sum[i] >= (1 << WV[i])) ? 1 : 0;
          held[i]  = 1'b1;
          q_sum[i] = 0;
          q_n[i]   = 0;
        end
      end else if (ordy[i]) begin
        held[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d_in_ready", i), {31'b0, ir[i]}, {31'b0, !held[i]});
      chk($sformatf("i%0d_out_valid", i), {31'b0, ov[i]}, {31'b0, held[i]});
      chk($sformatf("i%0d_out_sum", i), {24'b0, osum[i]}, e_sum[i]);
      chk($sformatf("i%0d_out_count", i), {27'b0, ocnt[i]}, e_cnt[i]);
      chk($sformatf("i%0d_out_ovf", i), {31'b0, oovf[i]}, e_ovf[i]);
    end
  endtask

  task automatic put(input int i, input logic v, input logic [2:0] s, input logic f);
    iv[i] = v; smp[i] = s; fl[i] = f;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1; smp[i] = 3'd0;
      held[i] = 1'b0; q_sum[i] = 0; q_n[i] = 0;
      e_sum[i] = 0; e_cnt[i] = 0; e_ovf[i] = 0;
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", {31'b0, ir[0]}, 32'd1);
    chk("reset_out_valid", {31'b0, ov[0]}, 32'd0);
    chk("reset_out_sum", {24'b0, osum[0]}, 32'd0);

    // full frame of 6s
    for (int k = 0; k < 4; k++) put(0, 1'b1, 3'd6, 1'b0);
    chk("full_sum", {24'b0, osum[0]}, 32'd24);
    chk("full_count", {27'b0, ocnt[0]}, 32'd4);
    chk("full_ovf", {31'b0, oovf[0]}, 32'd0);
    chk("full_in_ready_low", {31'b0, ir[0]}, 32'd0);
    put(0, 1'b0, 3'd0, 1'b0);
    chk("full_in_ready_back", {31'b0, ir[0]}, 32'd1);
    chk("full_valid_one_cycle", {31'b0, ov[0]}, 32'd0);

    // overflow on the 4-bit instance, then a clean frame
    for (int k = 0; k < 4; k++) put(1, 1'b1, 3'd6, 1'b0);
    chk("ovf_sum", {24'b0, osum[1]}, 32'd8);
    chk("ovf_flag", {31'b0, oovf[1]}, 32'd1);
    put(1, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) put(1, 1'b1, 3'd1, 1'b0);
    chk("ovf_next_sum", {24'b0, osum[1]}, 32'd4);
    chk("ovf_next_flag", {31'b0, oovf[1]}, 32'd0);
    put(1, 1'b0, 3'd0, 1'b0);

    // backpressure: frame 1,2,3,4 held while sample 5 waits upstream
    ordy[0] = 1'b0;
    for (int k = 1; k <= 4; k++) put(0, 1'b1, 3'(k), 1'b0);
    for (int k = 0; k < 5; k++) begin
      put(0, 1'b1, 3'd5, 1'b0);
      chk("bp_in_ready", {31'b0, ir[0]}, 32'd0);
      chk("bp_sum", {24'b0, osum[0]}, 32'd10);
      chk("bp_count", {27'b0, ocnt[0]}, 32'd4);
    end
    ordy[0] = 1'b1;
    put(0, 1'b1, 3'd5, 1'b0);
    chk("bp_release", {31'b0, ov[0]}, 32'd0);
    chk("bp_hold_sum", {24'b0, osum[0]}, 32'd10);
    put(0, 1'b1, 3'd5, 1'b0);
    for (int k = 0; k < 3; k++) put(0, 1'b1, 3'd0, 1'b0);
    chk("bp_next_sum", {24'b0, osum[0]}, 32'd5);
    put(0, 1'b0, 3'd0, 1'b0);

    // flush cases
    put(0, 1'b1, 3'd5, 1'b0);
    put(0, 1'b1, 3'd7, 1'b0);
    put(0, 1'b0, 3'd0, 1'b1);
    chk("flush_valid", {31'b0, ov[0]}, 32'd1);
    chk("flush_sum", {24'b0, osum[0]}, 32'd12);
    chk("flush_count", {27'b0, ocnt[0]}, 32'd2);
    put(0, 1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      put(0, 1'b0, 3'd0, 1'b1);
      chk("flush_empty_no_valid", {31'b0, ov[0]}, 32'd0);
    end
    put(0, 1'b1, 3'd2, 1'b0);
    put(0, 1'b1, 3'd3, 1'b1);
    chk("flush_acc_sum", {24'b0, osum[0]}, 32'd5);
    chk("flush_acc_count", {27'b0, ocnt[0]}, 32'd2);
    put(0, 1'b0, 3'd0, 1'b0);

    // reset mid-frame
    put(0, 1'b1, 3'd6, 1'b0);
    put(0, 1'b1, 3'd6, 1'b0);
    iv[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {31'b0, ov[0]}, 32'd0);
    chk("rst_mid_ready", {31'b0, ir[0]}, 32'd1);
    for (int k = 0; k < 4; k++) put(0, 1'b1, 3'd1, 1'b0);
    chk("rst_next_sum", {24'b0, osum[0]}, 32'd4);
    chk("rst_next_count", {27'b0, ocnt[0]}, 32'd4);
    put(0, 1'b0, 3'd0, 1'b0);

    // exhaustive 2-bit adder feed into the 16-sample instance
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        put(2, 1'b1, 3'(a + b), 1'b0);
    chk("exh_sum", {24'b0, osum[2]}, 32'd48);
    chk("exh_count", {27'b0, ocnt[2]}, 32'd16);
    chk("exh_ovf", {31'b0, oovf[2]}, 32'd0);
    put(2, 1'b0, 3'd0, 1'b0);

    // randomized traffic on all instances against the frame model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        smp[i]  = 3'($urandom_range(0, 7));
        fl[i]   = ($urandom_range(0, 7) == 0);
        ordy[i] = ($urandom_range(0, 1) == 1);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/add2_acc.md
# add2_acc

Registered accumulation stage directly downstream of the combinational 2-bit adder. It consumes the adder's 3-bit result `{c1, s1, s0}` (value 0..6) under a valid/ready handshake and sums a frame of `COUNT` results into an `ACC_W`-bit accumulator. It presents the frame total, sample count and an overflow flag on a held output handshake, so downstream logic sees one word per frame instead of one adder result per cycle.

## Interface

Parameters:
- `ACC_W`, default 8, accumulator and `out_sum` width; must be ≥ 3.
- `COUNT`, default 4, samples per full frame; must be ≥ 1.

Ports (`CW` = clog2(COUNT+1)):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  adder result on `c1`/`s1`/`s0` is valid.
- `in_ready`  out  1  stage accepts a sample this cycle.
- `s0`  in  1  adder sum bit 0.
- `s1`  in  1  adder sum bit 1.
- `c1`  in  1  adder carry-out (sample bit 2).
- `flush`  in  1  close the current partial frame early.
- `out_valid`  out  1  frame result is held on the outputs.
- `out_ready`  in  1  downstream takes the frame result.
- `out_sum`  out  `ACC_W`  frame total, modulo 2^ACC_W.
- `out_count`  out  `CW`  number of samples in the frame (1..COUNT).
- `out_ovf`  out  1  at least one accumulation in the frame carried out of `ACC_W` bits.

## Operation

- **Sample value:** `smp = {c1, s1, s0}`, zero-extended to `ACC_W + 1` bits.
- **Accept:** an accept occurs when `in_valid && in_ready`.
- **States:** two, `ACCUM` and `HOLD`.
  - `in_ready = (state == ACCUM)`, decoded from registered state only and never from `in_valid` or `out_ready`.
  - `out_valid = (state == HOLD)`.
- **ACCUM, on accept:**
  - `{carry, acc_next} = acc + smp`; `acc <= acc_next`.
  - `ovf <= ovf | carry`.
  - `cnt <= cnt + 1`.
- **ACCUM, frame close:** the frame closes on the same edge when either
  - an accept occurs with `cnt == COUNT-1`, or
  - `flush` is high and (`cnt > 0` or an accept occurs).
- **On frame close:**
  - `out_sum`, `out_count`, `out_ovf` load the post-update values.
  - State goes to `HOLD`.
  - `acc`, `cnt`, `ovf` clear to 0.
- **Flush edge cases:**
  - `flush` with `cnt == 0` and no accept is ignored; no empty frame is ever emitted.
  - `flush` in `HOLD` is ignored.
- **Simultaneous accept + flush:** the accepted sample is included, then the frame closes.
- **HOLD:**
  - `out_sum`, `out_count`, `out_ovf` remain stable.
  - On `out_valid && out_ready`, return to `ACCUM`.
  - No input is accepted during `HOLD`. Upstream holds its sample and no data is dropped.
- **Arithmetic:** wrap modulo 2^ACC_W; `out_ovf` is sticky within a frame and clears per frame.
- **Reset**, in any state and mid-frame: `state = ACCUM`; `acc`, `cnt`, `ovf` = 0. Partial frame contents are discarded.

## Timing

- **Reset values:**
  - `in_ready = 1` (first cycle after reset deasserts).
  - `out_valid = 0`.
  - `out_sum = 0`, `out_count = 0`, `out_ovf = 0`.
- **Latency:** `out_valid` rises on the edge that accepts the last sample of a frame, i.e. it is visible the cycle after that sample is presented.
- **Throughput:** with `out_ready` held high, a full frame takes `COUNT + 1` cycles: `COUNT` accept cycles plus 1 `HOLD` cycle.
- **HOLD exit:** `HOLD` with `out_ready` high lasts exactly one cycle; `in_ready` returns the next cycle.
- **Output stability:** outputs change only on the frame-close edge or under reset. They are not cleared when leaving `HOLD`.
- **Input sensitivity:** `in_valid`, `flush` and the sample bits are ignored while `in_ready = 0`.

## Test plan

- **Full frame** (`ACC_W=8`, `COUNT=4`): four back-to-back samples of 6 (`c1=1`, `s1=1`, `s0=0`), `out_ready=1`.
  - Expect `out_valid` for 1 cycle with `out_sum=24`, `out_count=4`, `out_ovf=0`.
  - `in_ready` is low for exactly that cycle.
- **Overflow** (`ACC_W=4`, `COUNT=4`): samples 6, 6, 6, 6.
  - Expect `out_sum=8`, `out_ovf=1`.
  - Next frame 1, 1, 1, 1 → `out_sum=4`, `out_ovf=0`.
- **Backpressure:** complete a frame of 1, 2, 3, 4 (`sum=10`) with `out_ready=0` for 5 cycles, while `in_valid=1` holds sample 5.
  - `in_ready=0` and outputs stay 10/4/0 throughout.
  - After `out_ready` pulses, sample 5 is accepted as the first sample of the next frame.
- **Flush:**
  - Samples 5, 7, then `flush` alone → `out_sum=12`, `out_count=2`.
  - `flush` with `cnt=0` and `in_valid=0` → no `out_valid`.
  - `flush` concurrent with sample 3 at `cnt=1` (prior sample 2) → `out_sum=5`, `out_count=2`.
- **Reset mid-frame:** accept 6, 6, then assert `rst` for 1 cycle.
  - Expect `out_valid=0`, `in_ready=1`.
  - A following 1, 1, 1, 1 frame → `out_sum=4`, `out_count=4`.
- **Exhaustive adder feed:** drive all 16 `(a1, a0, b1, b0)` combinations through the upstream adder into the block (`COUNT=16`, `ACC_W=8`).
  - Expect `out_sum=48`, `out_count=16`, `out_ovf=0`.
